// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the
// shadow-pipe entry that tracks one in-flight register write.
`timescale 1ns/1ps
package hazard_ctrl_pkg;

    // Destination field is sized for the widest register specifier supported;
    // narrower specifiers are zero-extended on the way in.
    localparam int DST_W = 8;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic             v;    // entry carries a real register write
        logic             ld;   // write comes from a load
        logic             hlt;  // HALT marker, may ride with v=0
        logic [DST_W-1:0] dst;  // destination register
    } shadow_entry_t;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Shadow shift register of in-flight writes, EX (entry 0) through WB.
// A redirect kills the instruction leaving EX by loading entry 1 with an
// empty entry; entry 0 takes a bubble whenever nothing issues.
`timescale 1ns/1ps
module hazard_shadow_pipe
    import hazard_ctrl_pkg::*;
#(
    parameter int WB_DIST = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_i,
    input  shadow_entry_t               din_i,
    input  logic                        kill_i,
    output shadow_entry_t [WB_DIST-1:0] entries_o
);

    shadow_entry_t [WB_DIST-1:0] entries_q;
    shadow_entry_t [WB_DIST-1:0] entries_d;

    // Next state: bubble or issued entry at EX, kill at MEM, plain shift after.
    always_comb begin
        entries_d    = '0;
        entries_d[0] = load_i ? din_i : '0;
        for (int i = 1; i < WB_DIST; i++) begin
            entries_d[i] = (i == 1 && kill_i) ? '0 : entries_q[i-1];
        end
    end

    // Stages after ID never stall, so the pipe shifts every cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) entries_q <= '0;
        else      entries_q <= entries_d;
    end

    assign entries_o = entries_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and flow controller for the 5-stage in-order pipeline: RAW and
// load-use interlocks, redirect flushing and a HALT drain state machine.
`timescale 1ns/1ps
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_BITS = 3,
    parameter int WB_DIST  = 3,
    parameter int FWD_EN   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic                id_rs_used,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic                id_rt_used,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_wr_en,
    input  logic [REG_BITS-1:0] id_wr_reg,
    input  logic                id_is_load,
    input  logic                id_halt,
    input  logic                redirect,
    output logic                stall_pc,
    output logic                stall_if_id,
    output logic                bubble_id_ex,
    output logic                flush_if_id,
    output logic                flush_ex_mem,
    output logic                halted,
    output logic                err
);

    shadow_entry_t [WB_DIST-1:0] ent;
    shadow_entry_t               din;
    state_e                      state_q;
    logic                        halted_q;
    logic                        err_q;
    logic                        hazard;
    logic                        issue;
    logic                        err_evt;

    assign din = '{v: id_wr_en, ld: id_is_load, hlt: id_halt, dst: DST_W'(id_wr_reg)};

    hazard_shadow_pipe #(.WB_DIST(WB_DIST)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .load_i    (issue),
        .din_i     (din),
        .kill_i    (redirect),
        .entries_o (ent)
    );

    // Interlock: WB is bypassed by the register file so it is never compared.
    // With forwarding only a load still in EX can't be forwarded in time.
    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            for (int i = 0; i < WB_DIST - 1; i++) begin
                if (ent[i].v && (FWD_EN == 0 || (i == 0 && ent[i].ld))) begin
                    if ((id_rs_used && ent[i].dst == DST_W'(id_rs)) ||
                        (id_rt_used && ent[i].dst == DST_W'(id_rt)))
                        hazard = 1'b1;
                end
            end
        end
    end

    assign issue   = id_valid && !hazard && !redirect && (state_q == ST_RUN);
    assign err_evt = (redirect && state_q == ST_HALTED) ||
                     (id_valid && id_halt && id_wr_en) ||
                     (id_halt && id_wr_en && !id_is_load);

    // Pipeline-register controls; redirect beats both hazard and drain stalls.
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        flush_if_id  = 1'b0;
        flush_ex_mem = 1'b0;
        if (state_q == ST_HALTED) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (redirect) begin
            flush_if_id  = 1'b1;
            flush_ex_mem = 1'b1;
            bubble_id_ex = 1'b1;
        end else if (hazard || state_q == ST_DRAIN) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end
        if (!rst) begin
            stall_pc     = 1'b0;
            stall_if_id  = 1'b0;
            bubble_id_ex = 1'b0;
            flush_if_id  = 1'b0;
            flush_ex_mem = 1'b0;
        end
    end

    // Run/drain/halt sequencing plus the sticky status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (err_evt) err_q <= 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (issue && id_halt) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    // Halt moving into WB this edge ends the drain.
                    if (redirect && ent[0].hlt) begin
                        state_q <= ST_RUN;
                    end else if (ent[WB_DIST-2].hlt) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                ST_HALTED: halted_q <= 1'b1;
                default:   state_q  <= ST_RUN;
            endcase
        end
    end

    assign halted = halted_q;
    assign err    = err_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard and flow controller for the 16-bit in-order pipeline: IF, ID, EX, MEM, WB.
- Keeps a shadow pipe of in-flight register writes from EX through WB.
- Produces the stall, bubble and flush controls for the pipeline registers.
- Replaces the free-running pipeline with load-use/RAW interlocking, redirect flushing and a halt-drain state machine.

Parameters:
- REG_BITS, 3, register specifier width; the register file has 2^REG_BITS entries.
- WB_DIST, 3, shadow-pipe depth in stages, EX through WB inclusive; range 2..6.
- FWD_EN, 1, 1 = forwarding datapath present, stall only on load-use; 0 = stall on any pending RAW.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  valid instruction in ID.
- id_rs_used  in  1  ID reads rs.
- id_rs  in  REG_BITS  rs specifier.
- id_rt_used  in  1  ID reads rt.
- id_rt  in  REG_BITS  rt specifier.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_reg  in  REG_BITS  destination register.
- id_is_load  in  1  ID instruction is a load.
- id_halt  in  1  ID instruction is HALT.
- redirect  in  1  taken branch/jump resolved by the instruction in MEM.
- stall_pc  out  1  hold PC.
- stall_if_id  out  1  hold IF/ID.
- bubble_id_ex  out  1  load NOP into ID/EX.
- flush_if_id  out  1  clear IF/ID.
- flush_ex_mem  out  1  clear EX/MEM on next edge, killing the EX-stage instruction.
- halted  out  1  processor halted, sticky.
- err  out  1  illegal event, sticky.

Behaviour:
- Reset (rst=0, async): all shadow entries invalid, FSM=RUN, all outputs 0.
- Shadow pipe: WB_DIST entries {v, ld, hlt, dst}; entry 0 is EX, entry WB_DIST-1 is WB. Shifts every cycle; stages after ID never stall.
- Entry 0 loads {id_wr_en, id_is_load, id_halt, id_wr_reg} when issue=id_valid & ~hazard & ~redirect & FSM==RUN.
- Entry 0 loads bubble (all 0) otherwise.
- v=0 entries never match; hlt may be set with v=0.
- Register file bypasses the WB write to same-cycle reads, so the WB entry never causes a hazard.
- Match(r): used bit set, and entry v=1 with dst==r.
- Hazard with FWD_EN=0: Match against any entry 0..WB_DIST-2.
- Hazard with FWD_EN=1: Match against entry 0 with ld=1 only. Exactly one bubble per load-use.
- Hazard is evaluated only when id_valid=1.
- When hazard=1: stall_pc=stall_if_id=bubble_id_ex=1, combinational in the same cycle.
- When redirect=1:
  - flush_if_id=1, bubble_id_ex=1, flush_ex_mem=1.
  - Entry 1 receives invalid instead of entry 0.
  - Redirect overrides hazard: stall_pc=stall_if_id=0, so the PC loads the target.
- FSM RUN:
  - issue & id_halt -> DRAIN.
  - stall_pc, stall_if_id and bubble_id_ex follow the hazard/redirect rules.
- FSM DRAIN:
  - stall_pc=stall_if_id=bubble_id_ex=1; nothing new issues.
  - redirect while the halt is in entry 0 kills the halt -> RUN. The redirect flush outputs take priority that cycle.
  - The hlt bit reaching entry WB_DIST-1 -> HALTED.
- FSM HALTED:
  - stall_pc=stall_if_id=bubble_id_ex=1, halted=1.
  - Only reset exits this state.
- err is set by:
  - redirect while HALTED;
  - id_valid & id_halt & id_wr_en;
  - id_wr_en with id_is_load=0 asserted together with id_halt.
  
  err is sticky until reset.
- Reset mid-drain: returns to RUN with an empty shadow pipe in the same cycle.
- Simultaneous redirect and load-use: redirect wins, and no stall cycle is spent.

Decomposition:
- Shared package: FSM state enum {RUN, DRAIN, HALTED} and the shadow-entry struct {v, ld, hlt, dst}.
- One sub-module, hazard_shadow_pipe: the parametrised shift register with kill-at-entry-1 and bubble insert. It exports all entries as a flat vector for the comparators.

Test Plan:
- FWD_EN=1: LD r2 then ADD r3,r2,r1 back-to-back -> exactly 1 cycle with stall_pc=bubble_id_ex=1. ADD issues the following cycle.
- FWD_EN=0, WB_DIST=3: ADD r4 then SUB r5,r4,r4 -> 2 stall cycles; SUB issues when ADD is in WB.
- Branch in MEM with redirect=1 while ID holds a load-use hazard -> flush_if_id=flush_ex_mem=bubble_id_ex=1 and stall_pc=0 in that cycle. The killed EX entry never matches afterwards.
- HALT issued with no older hazards, WB_DIST=3 -> halted rises 3 cycles after issue. stall_pc stays 1 in DRAIN and afterwards.
- HALT in EX plus redirect from the branch in MEM -> FSM returns to RUN, halted stays 0, and the next instruction issues.
- Assert rst=0 mid-DRAIN, asynchronously between edges -> all outputs 0 immediately. After release, the first instruction issues with no spurious stall.
